// File: rtl/gh_pkg.sv
// Shared types and constants for the note-highway lane logic.
// Holds lane indices, playfield geometry and the lane FSM state type.
package gh_pkg;

    typedef enum logic [2:0] {
        GREEN  = 3'd0,
        RED    = 3'd1,
        YELLOW = 3'd2,
        BLUE   = 3'd3,
        ORANGE = 3'd4
    } lane_e;

    typedef enum logic {
        IDLE = 1'b0,
        FALL = 1'b1
    } lane_state_e;

    localparam int NUM_LANES    = 5;

    localparam int PLAYFIELD_LO = 150;
    localparam int PLAYFIELD_HI = 490;
    localparam int ZONE_LO      = 419;
    localparam int ZONE_HI      = 451;

    localparam int SPRITE_SIZE  = 40;
    localparam int LANE_X0      = 164;
    localparam int LANE_PITCH   = 68;

    function automatic logic [9:0] lane_x(input int lane);
        return 10'(LANE_X0 + lane * LANE_PITCH);
    endfunction

endpackage

// File: rtl/note_lane_ctrl_lane.sv
// One fret lane: note FSM, y position, pending spawn, strum edge
// detect and registered sprite hit-test.
// Ports: clk/rst_n, tick (one cycle per frame), spawn, strum level,
// draw_x/draw_y pixel, x_pos (lane constant), y_pos, is_sprite,
// hit/miss one-cycle pulses.
module note_lane
    import gh_pkg::*;
#(
    parameter int SPEED   = 4,
    parameter int SPAWN_Y = 0,
    parameter int HIT_LO  = 380,
    parameter int HIT_HI  = 451,
    parameter int MISS_Y  = 452
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       spawn,
    input  logic       strum,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    input  logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       is_sprite,
    output logic       hit,
    output logic       miss
);

    lane_state_e state_q, state_d;
    logic [9:0]  y_q, y_d;
    logic        pend_q, pend_d;
    logic        strum_d;
    logic        hit_d, miss_d;
    logic        strum_edge, in_win, in_box;
    logic [10:0] y_next;

    assign strum_edge = strum & ~strum_d;
    // 11 bits so the miss compare sees the carry and y never wraps
    assign y_next = {1'b0, y_q} + 11'(SPEED);
    assign in_win = (y_q >= 10'(HIT_LO)) && (y_q <= 10'(HIT_HI));

    assign in_box =
        ({1'b0, draw_x} >= {1'b0, x_pos}) &&
        ({1'b0, draw_x} <  {1'b0, x_pos} + 11'(SPRITE_SIZE)) &&
        ({1'b0, draw_y} >= {1'b0, y_q}) &&
        ({1'b0, draw_y} <  {1'b0, y_q} + 11'(SPRITE_SIZE));

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        pend_d  = pend_q | spawn;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick && (pend_q || spawn)) begin
                    state_d = FALL;
                    y_d     = 10'(SPAWN_Y);
                    pend_d  = 1'b0;
                end
            end
            FALL: begin
                // hit is judged on the pre-move y and beats the tick
                if (strum_edge && in_win) begin
                    state_d = IDLE;
                    hit_d   = 1'b1;
                end else if (tick) begin
                    if (y_next > 11'(MISS_Y)) begin
                        state_d = IDLE;
                        miss_d  = 1'b1;
                    end else begin
                        y_d = y_next[9:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            y_q       <= 10'(SPAWN_Y);
            pend_q    <= 1'b0;
            strum_d   <= 1'b0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            is_sprite <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            pend_q    <= pend_d;
            strum_d   <= strum;
            hit       <= hit_d;
            miss      <= miss_d;
            // registered to line up with the frame RAM read
            is_sprite <= (state_q == FALL) && in_box;
        end
    end

    assign y_pos = y_q;

endmodule

// File: rtl/note_lane_ctrl.sv
// Five-lane falling-note controller feeding color_mapper and scoring.
// Ports: Clk, Reset_n, frame_clk, spawn[4:0], strum[4:0], DrawX/DrawY,
// is_sprite_*, *_x_pos, *_y_pos, hit_pulse, miss_pulse, streak.
module note_lane_ctrl
    import gh_pkg::*;
#(
    parameter int SPEED   = 4,
    parameter int SPAWN_Y = 0,
    parameter int HIT_LO  = 380,
    parameter int HIT_HI  = 451,
    parameter int MISS_Y  = 452
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [4:0] spawn,
    input  logic [4:0] strum,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       is_sprite_green,
    output logic       is_sprite_red,
    output logic       is_sprite_yellow,
    output logic       is_sprite_blue,
    output logic       is_sprite_orange,
    output logic [9:0] green_x_pos,
    output logic [9:0] red_x_pos,
    output logic [9:0] yellow_x_pos,
    output logic [9:0] blue_x_pos,
    output logic [9:0] orange_x_pos,
    output logic [9:0] green_y_pos,
    output logic [9:0] red_y_pos,
    output logic [9:0] yellow_y_pos,
    output logic [9:0] blue_y_pos,
    output logic [9:0] orange_y_pos,
    output logic [4:0] hit_pulse,
    output logic [4:0] miss_pulse,
    output logic [7:0] streak
);

    logic       frame_clk_d;
    logic       tick;
    logic [9:0] x_pos  [NUM_LANES];
    logic [9:0] y_pos  [NUM_LANES];
    logic [4:0] sprite;

    assign tick = frame_clk & ~frame_clk_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) frame_clk_d <= 1'b0;
        else          frame_clk_d <= frame_clk;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign x_pos[i] = lane_x(i);

        note_lane #(
            .SPEED   (SPEED),
            .SPAWN_Y (SPAWN_Y),
            .HIT_LO  (HIT_LO),
            .HIT_HI  (HIT_HI),
            .MISS_Y  (MISS_Y)
        ) u_lane (
            .clk       (Clk),
            .rst_n     (Reset_n),
            .tick      (tick),
            .spawn     (spawn[i]),
            .strum     (strum[i]),
            .draw_x    (DrawX),
            .draw_y    (DrawY),
            .x_pos     (x_pos[i]),
            .y_pos     (y_pos[i]),
            .is_sprite (sprite[i]),
            .hit       (hit_pulse[i]),
            .miss      (miss_pulse[i])
        );
    end

    // a miss anywhere breaks the run, even alongside a hit elsewhere
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            streak <= 8'd0;
        end else if (|miss_pulse) begin
            streak <= 8'd0;
        end else if ((|hit_pulse) && (streak != 8'hFF)) begin
            streak <= streak + 8'd1;
        end
    end

    assign is_sprite_green  = sprite[GREEN];
    assign is_sprite_red    = sprite[RED];
    assign is_sprite_yellow = sprite[YELLOW];
    assign is_sprite_blue   = sprite[BLUE];
    assign is_sprite_orange = sprite[ORANGE];

    assign green_x_pos  = x_pos[GREEN];
    assign red_x_pos    = x_pos[RED];
    assign yellow_x_pos = x_pos[YELLOW];
    assign blue_x_pos   = x_pos[BLUE];
    assign orange_x_pos = x_pos[ORANGE];

    assign green_y_pos  = y_pos[GREEN];
    assign red_y_pos    = y_pos[RED];
    assign yellow_y_pos = y_pos[YELLOW];
    assign blue_y_pos   = y_pos[BLUE];
    assign orange_y_pos = y_pos[ORANGE];

endmodule

// File: tb/tb_note_lane_ctrl.sv
// Bench for note_lane_ctrl: scenario tasks plus a hit/miss event
// scoreboard fed by the tasks and drained by a negedge monitor.
module tb_note_lane_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [4:0] spawn = '0;
    logic [4:0] strum = '0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       is_sprite_green, is_sprite_red, is_sprite_yellow;
    logic       is_sprite_blue, is_sprite_orange;
    logic [9:0] green_x_pos, red_x_pos, yellow_x_pos;
    logic [9:0] blue_x_pos, orange_x_pos;
    logic [9:0] green_y_pos, red_y_pos, yellow_y_pos;
    logic [9:0] blue_y_pos, orange_y_pos;
    logic [4:0] hit_pulse, miss_pulse;
    logic [7:0] streak;

    note_lane_ctrl dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .frame_clk        (frame_clk),
        .spawn            (spawn),
        .strum            (strum),
        .DrawX            (DrawX),
        .DrawY            (DrawY),
        .is_sprite_green  (is_sprite_green),
        .is_sprite_red    (is_sprite_red),
        .is_sprite_yellow (is_sprite_yellow),
        .is_sprite_blue   (is_sprite_blue),
        .is_sprite_orange (is_sprite_orange),
        .green_x_pos      (green_x_pos),
        .red_x_pos        (red_x_pos),
        .yellow_x_pos     (yellow_x_pos),
        .blue_x_pos       (blue_x_pos),
        .orange_x_pos     (orange_x_pos),
        .green_y_pos      (green_y_pos),
        .red_y_pos        (red_y_pos),
        .yellow_y_pos     (yellow_y_pos),
        .blue_y_pos       (blue_y_pos),
        .orange_y_pos     (orange_y_pos),
        .hit_pulse        (hit_pulse),
        .miss_pulse       (miss_pulse),
        .streak           (streak)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0] hit;
        logic [4:0] miss;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    wire [49:0] all_y = {orange_y_pos, blue_y_pos, yellow_y_pos,
                         red_y_pos, green_y_pos};
    wire [49:0] all_x = {orange_x_pos, blue_x_pos, yellow_x_pos,
                         red_x_pos, green_x_pos};
    wire [4:0]  all_s = {is_sprite_orange, is_sprite_blue,
                         is_sprite_yellow, is_sprite_red,
                         is_sprite_green};

    // scoreboard: every nonzero pulse cycle must match the next entry
    always @(negedge Clk) begin
        ev_t e;
        if (Reset_n && ((hit_pulse != '0) || (miss_pulse != '0))) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event_unexpected: hit=%b miss=%b, none expected",
                         hit_pulse, miss_pulse);
            end else begin
                e = exp_q.pop_front();
                if ({hit_pulse, miss_pulse} !== {e.hit, e.miss}) begin
                    errors++;
                    $display("FAIL event: hit=%b miss=%b, expected hit=%b miss=%b",
                             hit_pulse, miss_pulse, e.hit, e.miss);
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) frame_tick();
    endtask

    // spawn pulse then one tick: the lanes in mask start at y=0
    task automatic launch(input logic [4:0] mask);
        spawn = mask;
        step();
        spawn = '0;
        frame_tick();
    endtask

    task automatic drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d events never seen, expected 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (all_y !== 50'd0) begin
            errors++;
            $display("FAIL reset_y: got %h expected 0", all_y);
        end
        checks++;
        if (all_x !== {10'd436, 10'd368, 10'd300, 10'd232, 10'd164}) begin
            errors++;
            $display("FAIL reset_x: got %h", all_x);
        end
        checks++;
        if ({all_s, hit_pulse, miss_pulse, streak} !== 23'd0) begin
            errors++;
            $display("FAIL reset_flags: sprite=%b hit=%b miss=%b streak=%0d expected 0",
                     all_s, hit_pulse, miss_pulse, streak);
        end
        step();
        Reset_n = 1'b1;
        step();
    endtask

    task automatic test_hit();
        launch(5'b00001);
        ticks(95);
        checks++;
        if (green_y_pos !== 10'd380) begin
            errors++;
            $display("FAIL hit_y380: got %0d expected 380", green_y_pos);
        end
        exp_q.push_back('{hit: 5'b00001, miss: 5'b00000});
        strum = 5'b00001;
        step();
        step();
        checks++;
        if (streak !== 8'd1) begin
            errors++;
            $display("FAIL hit_streak: got %0d expected 1", streak);
        end
        checks++;
        if (hit_pulse !== 5'd0) begin
            errors++;
            $display("FAIL hit_one_cycle: got %b expected 0", hit_pulse);
        end
        strum = '0;
        DrawX = 10'd170;
        DrawY = 10'd390;
        step();
        step();
        checks++;
        if (is_sprite_green !== 1'b0) begin
            errors++;
            $display("FAIL hit_idle_sprite: got %b expected 0", is_sprite_green);
        end
        drained("hit");
    endtask

    task automatic test_miss();
        launch(5'b10000);
        ticks(113);
        checks++;
        if (orange_y_pos !== 10'd452) begin
            errors++;
            $display("FAIL miss_y452: got %0d expected 452", orange_y_pos);
        end
        exp_q.push_back('{hit: 5'b00000, miss: 5'b10000});
        frame_tick();
        checks++;
        if (streak !== 8'd0) begin
            errors++;
            $display("FAIL miss_streak: got %0d expected 0", streak);
        end
        checks++;
        if (orange_y_pos !== 10'd452) begin
            errors++;
            $display("FAIL miss_nowrap: got %0d expected 452", orange_y_pos);
        end
        drained("miss");
    endtask

    task automatic test_window_sprite();
        launch(5'b00010);
        ticks(25);
        strum = 5'b00010;
        step();
        strum = '0;
        step();
        step();
        checks++;
        if (red_y_pos !== 10'd100) begin
            errors++;
            $display("FAIL early_strum_y: got %0d expected 100", red_y_pos);
        end
        ticks(25);
        DrawX = 10'd232;
        DrawY = 10'd200;
        step();
        checks++;
        if (is_sprite_red !== 1'b1) begin
            errors++;
            $display("FAIL sprite_corner: got %b expected 1", is_sprite_red);
        end
        DrawX = 10'd272;
        step();
        checks++;
        if (is_sprite_red !== 1'b0) begin
            errors++;
            $display("FAIL sprite_xedge: got %b expected 0", is_sprite_red);
        end
        DrawX = 10'd232;
        DrawY = 10'd239;
        step();
        checks++;
        if (is_sprite_red !== 1'b1) begin
            errors++;
            $display("FAIL sprite_ylast: got %b expected 1", is_sprite_red);
        end
        DrawY = 10'd240;
        step();
        checks++;
        if (is_sprite_red !== 1'b0) begin
            errors++;
            $display("FAIL sprite_yedge: got %b expected 0", is_sprite_red);
        end
        ticks(62);
        checks++;
        if (red_y_pos !== 10'd448) begin
            errors++;
            $display("FAIL window_y448: got %0d expected 448", red_y_pos);
        end
        exp_q.push_back('{hit: 5'b00010, miss: 5'b00000});
        strum = 5'b00010;
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        step();
        strum = '0;
        checks++;
        if (streak !== 8'd1) begin
            errors++;
            $display("FAIL tick_hit_streak: got %0d expected 1", streak);
        end
        ticks(3);
        checks++;
        if (red_y_pos !== 10'd448) begin
            errors++;
            $display("FAIL tick_hit_y: got %0d expected 448", red_y_pos);
        end
        drained("window");
    endtask

    task automatic test_reset_mid_fall();
        launch(5'b00100);
        ticks(50);
        checks++;
        if (yellow_y_pos !== 10'd200) begin
            errors++;
            $display("FAIL midfall_y: got %0d expected 200", yellow_y_pos);
        end
        DrawX = 10'd300;
        DrawY = 10'd210;
        step();
        checks++;
        if (is_sprite_yellow !== 1'b1) begin
            errors++;
            $display("FAIL midfall_sprite: got %b expected 1", is_sprite_yellow);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({yellow_y_pos, is_sprite_yellow, streak} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: y=%0d sprite=%b streak=%0d expected 0",
                     yellow_y_pos, is_sprite_yellow, streak);
        end
        step();
        Reset_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        int exp_streak = 0;
        for (int r = 0; r < 52; r++) begin
            launch(5'b11111);
            ticks(95);
            for (int i = 0; i < 5; i++) begin
                exp_q.push_back('{hit: 5'(1 << i), miss: 5'b00000});
                strum = strum | 5'(1 << i);
                step();
            end
            strum = '0;
            step();
            exp_streak = (exp_streak + 5 > 255) ? 255 : exp_streak + 5;
            checks++;
            if (streak !== 8'(exp_streak)) begin
                errors++;
                $display("FAIL streak_round%0d: got %0d expected %0d",
                         r, streak, exp_streak);
            end
        end
        launch(5'b01000);
        ticks(113);
        exp_q.push_back('{hit: 5'b00000, miss: 5'b01000});
        frame_tick();
        checks++;
        if (streak !== 8'd0) begin
            errors++;
            $display("FAIL streak_clear: got %0d expected 0", streak);
        end
        drained("b2b");
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_window_sprite();
        test_reset_mid_fall();
        test_back_to_back();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
